// File: rtl/axe_clk_gen_ctrl_if.sv
// Requester-side and clock-generator-side signals of the axe clock generator controller.
// Handshake: a requester raises i_req_valid[k] with stable payload and holds both until it
// sees the one-cycle o_req_ready[k]; o_rsp_valid[k] later pulses once with o_rsp_err.
interface axe_clk_gen_ctrl_if #(
  parameter int NUM_REQ = 4
);
  logic                   i_sw_enable;
  logic [NUM_REQ-1:0]     i_req_valid;
  logic [NUM_REQ-1:0]     o_req_ready;
  logic [NUM_REQ*16-1:0]  i_req_freq_mhz;
  logic [NUM_REQ*7-1:0]   i_req_duty;
  logic [NUM_REQ-1:0]     o_rsp_valid;
  logic                   o_rsp_err;
  logic                   o_busy;
  logic                   o_clk_en;
  logic                   o_cfg_valid;
  logic [15:0]            o_cfg_freq_mhz;
  logic [6:0]             o_cfg_duty;
  logic [2:0]             dbg_state;

  modport master (
    output i_sw_enable, i_req_valid, i_req_freq_mhz, i_req_duty,
    input  o_req_ready, o_rsp_valid, o_rsp_err, o_busy, o_clk_en,
    input  o_cfg_valid, o_cfg_freq_mhz, o_cfg_duty, dbg_state
  );

  modport slave (
    input  i_sw_enable, i_req_valid, i_req_freq_mhz, i_req_duty,
    output o_req_ready, o_rsp_valid, o_rsp_err, o_busy, o_clk_en,
    output o_cfg_valid, o_cfg_freq_mhz, o_cfg_duty, dbg_state
  );
endinterface

// File: rtl/axe_clk_gen_ctrl.sv
// Round-robin arbiter/sequencer that gates, reconfigures and re-enables a shared
// axe_clk_generator on behalf of NUM_REQ requesters.
module axe_clk_gen_ctrl #(
  parameter int NUM_REQ          = 4,
  parameter int GATE_CYCLES      = 4,
  parameter int SETTLE_CYCLES    = 8,
  parameter int DEFAULT_FREQ_MHZ = 800,
  parameter int DEFAULT_DUTY     = 50
) (
  input logic              i_clk,
  input logic              i_rst,
  axe_clk_gen_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GATE   = 3'd1,
    S_APPLY  = 3'd2,
    S_SETTLE = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, gnt_q, gnt_d, pick;
  logic               found;
  int                 idx;
  logic [15:0]        cap_freq_q, cap_freq_d, cfg_freq_q, cfg_freq_d;
  logic [6:0]         cap_duty_q, cap_duty_d, cfg_duty_q, cfg_duty_d;
  logic [NUM_REQ-1:0] ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d, clk_en_q, clk_en_d, cfg_valid_q, cfg_valid_d;
  logic               cap_invalid, cap_same;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.i_req_valid[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  assign cap_invalid = (cap_freq_q == 16'd0) || (cap_duty_q == 7'd0) || (cap_duty_q >= 7'd100);
  assign cap_same    = (cap_freq_q == cfg_freq_q) && (cap_duty_q == cfg_duty_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cap_freq_d  = cap_freq_q;
    cap_duty_d  = cap_duty_q;
    cfg_freq_d  = cfg_freq_q;
    cfg_duty_d  = cfg_duty_q;
    ready_d     = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A ready pulse on the output means the grant was issued last edge:
        // this cycle decides on the captured payload instead of arbitrating.
        if (ready_q != '0) begin
          if (cap_invalid || cap_same) begin
            state_d = S_RESP;
          end else begin
            state_d = S_GATE;
            cnt_d   = CNT_W'(GATE_CYCLES);
          end
        end else if (found) begin
          ready_d[pick] = 1'b1;
          gnt_d         = pick;
          ptr_d         = (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          cap_freq_d    = bus.i_req_freq_mhz[int'(pick)*16 +: 16];
          cap_duty_d    = bus.i_req_duty[int'(pick)*7 +: 7];
        end
      end
      S_GATE: begin
        if (cnt_q == CNT_W'(1)) state_d = S_APPLY;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      S_APPLY: begin
        state_d = S_SETTLE;
        cnt_d   = CNT_W'(SETTLE_CYCLES);
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_APPLY) begin
      cfg_freq_d = cap_freq_q;
      cfg_duty_d = cap_duty_q;
    end
    if (state_d == S_RESP) begin
      rsp_valid_d[gnt_q] = 1'b1;
      rsp_err_d          = cap_invalid;
    end
    cfg_valid_d = (state_d == S_APPLY);
    busy_d      = (state_d != S_IDLE);
    clk_en_d    = ((state_d == S_IDLE) || (state_d == S_RESP)) ? bus.i_sw_enable : 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cap_freq_q  <= '0;
      cap_duty_q  <= '0;
      cfg_freq_q  <= 16'(DEFAULT_FREQ_MHZ);
      cfg_duty_q  <= 7'(DEFAULT_DUTY);
      ready_q     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cap_freq_q  <= cap_freq_d;
      cap_duty_q  <= cap_duty_d;
      cfg_freq_q  <= cfg_freq_d;
      cfg_duty_q  <= cfg_duty_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      clk_en_q    <= clk_en_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign bus.o_req_ready    = ready_q;
  assign bus.o_rsp_valid    = rsp_valid_q;
  assign bus.o_rsp_err      = rsp_err_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_clk_en       = clk_en_q;
  assign bus.o_cfg_valid    = cfg_valid_q;
  assign bus.o_cfg_freq_mhz = cfg_freq_q;
  assign bus.o_cfg_duty     = cfg_duty_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: doc/axe_clk_gen_ctrl.md
Name: axe_clk_gen_ctrl

Overview:
- Round-robin arbiter and sequencer that lets NUM_REQ requesters reconfigure a single shared axe_clk_generator, i.e. change its frequency and duty cycle.
- For each accepted request it validates the config, gates the clock, applies the new config, waits for the clock to settle, re-enables the clock and responds.
- It sits between the requester agents and the clock generator's enable and config inputs.

Parameters:
- NUM_REQ, 4, number of requesters (1..16).
- GATE_CYCLES, 4, cycles o_clk_en is held low before the config is applied (>=1).
- SETTLE_CYCLES, 8, cycles held gated after the config is applied (>=1).
- DEFAULT_FREQ_MHZ, 800, reset value of o_cfg_freq_mhz.
- DEFAULT_DUTY, 50, reset value of o_cfg_duty (percent).

Ports:
- i_clk  in  1  controller clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_sw_enable  in  1  global clock enable request.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- i_req_freq_mhz  in  NUM_REQ*16  packed requested frequency; slice k belongs to requester k.
- i_req_duty  in  NUM_REQ*7  packed requested duty in percent.
- o_rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- o_rsp_err  out  1  error flag, qualified by any o_rsp_valid bit.
- o_busy  out  1  high whenever state != IDLE.
- o_clk_en  out  1  drives the generator's i_enable.
- o_cfg_valid  out  1  one-cycle config-apply strobe.
- o_cfg_freq_mhz  out  16  current applied frequency.
- o_cfg_duty  out  7  current applied duty.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_req_ready, o_rsp_valid, o_rsp_err, o_busy, o_cfg_valid, o_clk_en = 0.
  - o_cfg_freq_mhz = DEFAULT_FREQ_MHZ; o_cfg_duty = DEFAULT_DUTY.
  - RR pointer = 0; state = IDLE.
- FSM states: IDLE, GATE, APPLY, SETTLE, RESP.
- o_clk_en register next value = i_sw_enable when the next state is IDLE or RESP, otherwise 0. It follows i_sw_enable with 1-cycle latency while idle.
- IDLE:
  - If any i_req_valid is high, grant the first set index at or after the RR pointer, wrapping.
  - o_req_ready[k] pulses in the next cycle (cycle T); payload is captured at T.
  - The pointer becomes (k+1) mod NUM_REQ.
  - Requesters hold valid and payload until they see ready; valid may drop without a grant.
- Decision at T+1, from the captured payload:
  - Invalid (freq == 0, duty == 0, or duty >= 100): go to RESP with err = 1. Config and o_clk_en are untouched.
  - Equal to the current config: go to RESP with err = 0 and no gating.
  - Otherwise: go to GATE.
- GATE: o_clk_en = 0; stay GATE_CYCLES cycles, then APPLY.
- APPLY (1 cycle): o_cfg_valid = 1; o_cfg_freq_mhz and o_cfg_duty take the captured values in this cycle; then SETTLE.
- SETTLE: stay SETTLE_CYCLES cycles, then RESP.
- RESP (1 cycle): o_rsp_valid[k] = 1 with o_rsp_err; then IDLE. A new grant is possible no earlier than the cycle after returning to IDLE.
- Full-path latency, ready to rsp_valid: 1 + GATE_CYCLES + 1 + SETTLE_CYCLES cycles. Bypass and invalid paths: 1 cycle.
- Counters are clog2(max(GATE_CYCLES, SETTLE_CYCLES)+1) wide; they load at state entry and count down to 1.
- Requests arriving while busy are not granted; valids are sampled only in IDLE.
- i_sw_enable low during a sequence: the sequence completes normally and o_clk_en stays 0 afterwards.
- i_sw_enable toggling during GATE/APPLY/SETTLE has no effect on o_clk_en.
- i_rst mid-sequence:
  - Abort with no response.
  - The config returns to defaults; the pending requester must re-request.
- Only one requester is ever in flight; o_req_ready and o_rsp_valid are each at most one-hot.

Test Plan:
1. Reset, i_sw_enable = 1, no requests -> o_cfg = 800 MHz / 50 %; o_clk_en = 1 from the second cycle after reset release; o_busy = 0.
2. Req0 with 1000 MHz / 20 %, defaults GATE = 4, SETTLE = 8 -> ready0 at T; o_clk_en = 0 for T+1..T+13; o_cfg_valid at T+5 with 1000/20; rsp_valid0 at T+14 with err = 0; o_clk_en = 1 at T+14.
3. Req1, req2 and req3 all valid with the pointer at 2 -> grants in order 2, 3, 1. Each completes before the next ready; no overlapping rsp.
4. Req0 with duty 100, then freq 0 -> each gets rsp err = 1 at T+1; o_clk_en never drops; cfg unchanged.
5. Req with 800/50 right after reset -> rsp err = 0 at T+1; no o_cfg_valid; o_clk_en stays 1.
6. Req 333 MHz / 60 %, i_sw_enable dropped in SETTLE, i_rst asserted in the next run's GATE -> first rsp arrives with o_clk_en staying 0; after the reset, no rsp is issued, cfg = 800/50, o_busy = 0.
